// File: rtl/if_id_ctrl_if.sv
// IF/ID pipeline-control bundle: hazard/redirect requests in, IF/ID register and PC controls out.
interface if_id_ctrl_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;
  logic        PC_write;
  logic        ID_EX_bubble;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;
  logic [15:0] stall_count;
  logic        stall_err;

  modport master (
    output stall, branch_taken, IF_pc, IF_inst,
    input  PC_write, ID_EX_bubble, IF_ID_pc, IF_ID_inst, IF_ID_valid, stall_count, stall_err
  );

  modport slave (
    input  stall, branch_taken, IF_pc, IF_inst,
    output PC_write, ID_EX_bubble, IF_ID_pc, IF_ID_inst, IF_ID_valid, stall_count, stall_err
  );
endinterface

// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register with stall/flush control, stall statistics and a sticky overlong-stall flag.
module if_id_ctrl #(
  parameter logic [31:0] NOP_INST    = 32'h0000_0000,
  parameter int unsigned STALL_LIMIT = 3
) (
  input  logic         CLK,
  input  logic         RSTn,
  if_id_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        eff_stall;
  logic [2:0]  run_cnt;
  logic [2:0]  run_nxt;
  logic [3:0]  run_inc;
  logic        err_set;

  // A stall against a bubble has nothing to protect, and a redirect overrides it.
  assign eff_stall = bus.stall & bus.IF_ID_valid & ~bus.branch_taken;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // All three states share one decision table; FLUSH lasts exactly one cycle by construction.
  always_comb begin
    bus.PC_write     = 1'b1;
    bus.ID_EX_bubble = 1'b0;
    state_nxt        = RUN;
    if (RSTn) begin
      case (state)
        RUN, STALL, FLUSH: begin
          if (bus.branch_taken) begin
            bus.ID_EX_bubble = 1'b1;
            state_nxt        = FLUSH;
          end else if (eff_stall) begin
            bus.PC_write     = 1'b0;
            bus.ID_EX_bubble = 1'b1;
            state_nxt        = STALL;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    run_inc = {1'b0, run_cnt} + 4'd1;
    run_nxt = '0;
    err_set = 1'b0;
    if (eff_stall) begin
      run_nxt = (run_cnt == 3'd7) ? 3'd7 : run_inc[2:0];
      err_set = 32'(run_inc) > STALL_LIMIT;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      bus.IF_ID_pc    <= '0;
      bus.IF_ID_inst  <= NOP_INST;
      bus.IF_ID_valid <= 1'b0;
      bus.stall_count <= '0;
      bus.stall_err   <= 1'b0;
      run_cnt         <= '0;
    end else begin
      run_cnt <= run_nxt;
      if (err_set) begin
        bus.stall_err <= 1'b1;
      end
      if (eff_stall && (bus.stall_count != '1)) begin
        bus.stall_count <= bus.stall_count + 16'd1;
      end
      if (bus.branch_taken) begin
        bus.IF_ID_inst  <= NOP_INST;
        bus.IF_ID_valid <= 1'b0;
      end else if (!eff_stall) begin
        bus.IF_ID_pc    <= bus.IF_pc;
        bus.IF_ID_inst  <= bus.IF_inst;
        bus.IF_ID_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed self-checking bench for if_id_ctrl.
module tb_if_id_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  if_id_ctrl_if bus();

  if_id_ctrl #(
    .NOP_INST    (NOP),
    .STALL_LIMIT (3)
  ) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.IF_pc = 32'h100;
    bus.IF_inst = 32'hDEAD_BEEF;
    step();
    checks++; if (bus.IF_ID_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", bus.IF_ID_pc); end
    checks++; if (bus.IF_ID_inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", bus.IF_ID_inst, NOP); end
    checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.IF_ID_valid); end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.stall_count); end
    checks++; if (bus.stall_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.stall_err); end
    checks++; if (bus.PC_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %b want 1", bus.PC_write); end
    checks++; if (bus.ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b want 0", bus.ID_EX_bubble); end
    bus.branch_taken = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_ignored_stall();
    bus.stall = 1'b1;
    bus.IF_pc = 32'h40;
    bus.IF_inst = 32'h1234_5678;
    #1;
    checks++; if (bus.PC_write !== 1'b1) begin errors++; $display("FAIL ign_pc_write: got %b want 1", bus.PC_write); end
    checks++; if (bus.ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL ign_bubble: got %b want 0", bus.ID_EX_bubble); end
    step();
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL ign_count: got %0d want 0", bus.stall_count); end
    checks++; if (bus.IF_ID_pc !== 32'h40 || bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL ign_load: got pc=%h v=%b want pc=00000040 v=1", bus.IF_ID_pc, bus.IF_ID_valid); end
    bus.stall = 1'b0;
  endtask

  task automatic test_straight_line();
    for (int i = 0; i < 3; i++) begin
      bus.IF_pc = 32'(i * 4);
      bus.IF_inst = 32'hA000_0000 + 32'(i);
      #1;
      checks++; if (bus.PC_write !== 1'b1) begin errors++; $display("FAIL line_pc_write[%0d]: got %b want 1", i, bus.PC_write); end
      step();
      checks++; if (bus.IF_ID_pc !== 32'(i * 4) || bus.IF_ID_inst !== 32'hA000_0000 + 32'(i) || bus.IF_ID_valid !== 1'b1) begin
        errors++; $display("FAIL line_ifid[%0d]: got pc=%h inst=%h v=%b want pc=%h", i, bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall2();
    bus.IF_pc = 32'hC;
    bus.IF_inst = 32'h8C01_0000;
    step();
    bus.IF_pc = 32'h10;
    bus.IF_inst = 32'h1111_1111;
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.PC_write !== 1'b0 || bus.ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL stall_ctrl[%0d]: got pcw=%b bub=%b want pcw=0 bub=1", i, bus.PC_write, bus.ID_EX_bubble); end
      step();
      checks++; if (bus.IF_ID_pc !== 32'hC || bus.IF_ID_inst !== 32'h8C01_0000 || bus.IF_ID_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got pc=%h inst=%h v=%b want pc=0000000c inst=8c010000 v=1", i, bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid);
      end
    end
    checks++; if (bus.stall_count !== 16'd2) begin errors++; $display("FAIL stall_count: got %0d want 2", bus.stall_count); end
    checks++; if (bus.stall_err !== 1'b0) begin errors++; $display("FAIL stall_err2: got %b want 0", bus.stall_err); end
    bus.stall = 1'b0;
    #1;
    checks++; if (bus.PC_write !== 1'b1 || bus.ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL stall_release: got pcw=%b bub=%b want pcw=1 bub=0", bus.PC_write, bus.ID_EX_bubble); end
    step();
    checks++; if (bus.IF_ID_pc !== 32'h10) begin errors++; $display("FAIL stall_resume: got %h want 00000010", bus.IF_ID_pc); end
  endtask

  task automatic test_branch_priority();
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.IF_pc = 32'h14;
    #1;
    checks++; if (bus.PC_write !== 1'b1 || bus.ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL br_ctrl: got pcw=%b bub=%b want pcw=1 bub=1", bus.PC_write, bus.ID_EX_bubble); end
    step();
    checks++; if (bus.IF_ID_inst !== NOP || bus.IF_ID_valid !== 1'b0 || bus.IF_ID_pc !== 32'h10) begin
      errors++; $display("FAIL br_flush: got pc=%h inst=%h v=%b want pc=00000010 inst=%h v=0", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid, NOP);
    end
    checks++; if (dut.state !== 2'd2) begin errors++; $display("FAIL br_state: got %0d want 2 (FLUSH)", dut.state); end
    checks++; if (bus.stall_count !== 16'd2) begin errors++; $display("FAIL br_count: got %0d want 2", bus.stall_count); end
    bus.branch_taken = 1'b0;
    bus.IF_pc = 32'h80;
    bus.IF_inst = 32'h2222_2222;
    #1;
    checks++; if (bus.PC_write !== 1'b1 || bus.ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL flush_ctrl: got pcw=%b bub=%b want pcw=1 bub=0", bus.PC_write, bus.ID_EX_bubble); end
    step();
    checks++; if (dut.state !== 2'd0 || bus.IF_ID_pc !== 32'h80 || bus.IF_ID_valid !== 1'b1) begin
      errors++; $display("FAIL flush_exit: got st=%0d pc=%h v=%b want st=0 pc=00000080 v=1", dut.state, bus.IF_ID_pc, bus.IF_ID_valid);
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_stall_err();
    bus.stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (bus.stall_err !== (i == 4)) begin errors++; $display("FAIL err_edge[%0d]: got %b want %b", i, bus.stall_err, (i == 4)); end
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.stall_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.stall_err); end
    checks++; if (bus.stall_count !== 16'd6) begin errors++; $display("FAIL err_count: got %0d want 6", bus.stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    bus.IF_pc = 32'h100;
    bus.IF_inst = 32'h3333_3333;
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (bus.stall_count !== 16'd5) begin errors++; $display("FAIL mid_count: got %0d want 5", bus.stall_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.IF_ID_pc !== 32'h0 || bus.IF_ID_inst !== NOP || bus.IF_ID_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ifid: got pc=%h inst=%h v=%b want 0/%h/0", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid, NOP);
    end
    checks++; if (bus.stall_count !== 16'd0 || bus.stall_err !== 1'b0) begin errors++; $display("FAIL mid_rst_stats: got cnt=%0d err=%b want 0/0", bus.stall_count, bus.stall_err); end
    checks++; if (bus.PC_write !== 1'b1 || bus.ID_EX_bubble !== 1'b0 || dut.state !== 2'd0) begin
      errors++; $display("FAIL mid_rst_ctrl: got pcw=%b bub=%b st=%0d want 1/0/0", bus.PC_write, bus.ID_EX_bubble, dut.state);
    end
    bus.IF_pc = 32'h200;
    bus.IF_inst = 32'h4444_4444;
    #1 rst_n = 1'b1;
    step();
    checks++; if (bus.IF_ID_pc !== 32'h200 || bus.IF_ID_inst !== 32'h4444_4444 || bus.IF_ID_valid !== 1'b1) begin
      errors++; $display("FAIL mid_resume: got pc=%h inst=%h v=%b want 00000200/44444444/1", bus.IF_ID_pc, bus.IF_ID_inst, bus.IF_ID_valid);
    end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL mid_resume_count: got %0d want 0", bus.stall_count); end
    bus.stall = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ignored_stall();
    test_straight_line();
    test_stall2();
    test_branch_priority();
    test_stall_err();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_ctrl.md
IF_ID_CTRL -- requirements
Module: if_id_ctrl

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0000; instruction word loaded into IF/ID on flush or reset.
REQ-002 SHALL have parameter STALL_LIMIT, default 3; longest legal consecutive-stall run before an error is flagged.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hazard-detect request to freeze IF/ID and bubble ID/EX.
REQ-006 SHALL have port branch_taken  input  1  EX-stage redirect; squash IF and ID.
REQ-007 SHALL have port IF_pc  input  32  PC of the instruction being fetched.
REQ-008 SHALL have port IF_inst  input  32  fetched instruction word.
REQ-009 SHALL have port PC_write  output  1  PC register load enable (combinational).
REQ-010 SHALL have port ID_EX_bubble  output  1  force ID/EX control fields to zero this cycle (combinational).
REQ-011 SHALL have port IF_ID_pc  output  32  registered PC of the ID-stage instruction.
REQ-012 SHALL have port IF_ID_inst  output  32  registered ID-stage instruction.
REQ-013 SHALL have port IF_ID_valid  output  1  registered; ID-stage instruction is real, not a bubble.
REQ-014 SHALL have port stall_count  output  16  registered total stall cycles, saturating.
REQ-015 SHALL have port stall_err  output  1  registered sticky flag; stall run exceeded STALL_LIMIT.

Function
REQ-016 SHALL implement state machine RUN, STALL, FLUSH; state held in one registered variable.
REQ-017 SHALL define effective stall eff_stall = stall AND IF_ID_valid AND NOT branch_taken; stall on an invalid IF/ID entry is ignored.
REQ-018 SHALL give branch_taken priority over stall when both are high in the same cycle.
REQ-019 SHALL, when branch_taken=1 in any state: PC_write=1, ID_EX_bubble=1; at the edge load IF_ID_inst=NOP_INST, IF_ID_valid=0, IF_ID_pc unchanged; next state FLUSH.
REQ-020 SHALL, when eff_stall=1: PC_write=0, ID_EX_bubble=1; at the edge hold IF_ID_pc, IF_ID_inst, IF_ID_valid; next state STALL.
REQ-021 SHALL, when neither branch_taken nor eff_stall: PC_write=1, ID_EX_bubble=0; at the edge load IF_ID_pc=IF_pc, IF_ID_inst=IF_inst, IF_ID_valid=1; next state RUN.
REQ-022 SHALL leave FLUSH after exactly one cycle, to RUN (or STALL/FLUSH per REQ-019/020 inputs that cycle); FLUSH applies REQ-019..021 identically.
REQ-023 SHALL keep a 3-bit run counter: +1 each eff_stall cycle, saturating at 7, cleared in any cycle without eff_stall.
REQ-024 SHALL set stall_err at the edge where the run counter would exceed STALL_LIMIT; stall_err stays 1 until reset.
REQ-025 SHALL increment stall_count by 1 on every eff_stall cycle, saturating at 16'hFFFF (no wrap).
REQ-026 SHALL have a one-edge latency from input to registered outputs; PC_write and ID_EX_bubble respond in the same cycle.

Reset
REQ-027 SHALL, while RSTn=0, force state=RUN, IF_ID_pc=0, IF_ID_inst=NOP_INST, IF_ID_valid=0, stall_count=0, stall_err=0, run counter=0.
REQ-028 SHALL drive PC_write=1 and ID_EX_bubble=0 while RSTn=0.
REQ-029 SHALL abort any STALL/FLUSH on mid-operation reset with no residual hold; the first edge after release loads IF into IF/ID.

Verification
REQ-030 SHALL test straight-line flow: stall=0, branch=0, IF_pc 0x0,0x4,0x8 -> IF_ID_pc follows one cycle later, IF_ID_valid=1, PC_write=1 throughout.
REQ-031 SHALL test a 2-cycle stall: valid IF_ID_inst=0x8C01_0000, stall=1 for 2 cycles -> PC_write=0 and ID_EX_bubble=1 for 2 cycles, IF/ID held, stall_count=2, stall_err=0.
REQ-032 SHALL test simultaneous stall=1 and branch_taken=1 -> PC_write=1, IF_ID_inst=NOP_INST, IF_ID_valid=0, state FLUSH, stall_count unchanged.
REQ-033 SHALL test 4 consecutive stalls with STALL_LIMIT=3 -> stall_err=1 after the 4th edge and still 1 after stall drops.
REQ-034 SHALL test stall=1 with IF_ID_valid=0 after reset -> ignored: PC_write=1, ID_EX_bubble=0, stall_count=0.
REQ-035 SHALL test RSTn pulsed low mid-STALL with stall_count=5 -> all registers return to REQ-027 values immediately, and normal flow resumes on the first edge after release.
